// File: rtl/miss_mem_arbiter.sv
// Arbitrates I$ and D$ miss traffic onto one memory port, one transaction in flight,
// with round-robin fairness and a response timeout that turns a hung access into a bus error.
module miss_mem_arbiter #(
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 20,
    parameter int THR_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic              ic_req_is_store,
    input  logic [LINE_W-1:0] ic_req_data,
    input  logic [THR_W-1:0]  ic_req_thread,
    input  logic              dc_req_valid,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_is_store,
    input  logic [LINE_W-1:0] dc_req_data,
    input  logic [THR_W-1:0]  dc_req_thread,
    output logic              ic_rsp_valid,
    output logic [LINE_W-1:0] ic_rsp_data,
    output logic              ic_rsp_error,
    output logic [THR_W-1:0]  ic_rsp_thread,
    output logic              dc_rsp_valid,
    output logic [LINE_W-1:0] dc_rsp_data,
    output logic              dc_rsp_error,
    output logic [THR_W-1:0]  dc_rsp_thread,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_is_store,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_error,
    output logic              protocol_err
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;          // 0 = I$, 1 = D$
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               perr_q;

    logic [1:0]         req_v, slot_v, slot_st, drop;
    logic [ADDR_W-1:0]  req_addr [2];
    logic [ADDR_W-1:0]  slot_addr [2];
    logic               req_st [2];
    logic [LINE_W-1:0]  req_data [2];
    logic [LINE_W-1:0]  slot_data [2];
    logic [THR_W-1:0]   req_thr [2];
    logic [THR_W-1:0]   slot_thr [2];

    assign req_v       = {dc_req_valid, ic_req_valid};
    assign req_addr[0] = ic_req_addr;
    assign req_addr[1] = dc_req_addr;
    assign req_st[0]   = ic_req_is_store;
    assign req_st[1]   = dc_req_is_store;
    assign req_data[0] = ic_req_data;
    assign req_data[1] = dc_req_data;
    assign req_thr[0]  = ic_req_thread;
    assign req_thr[1]  = dc_req_thread;

    // One-deep pending slot per source; the owner's RESP clear is applied before a new capture.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic              clr, occ;
        logic              v_q, st_q;
        logic [ADDR_W-1:0] addr_q;
        logic [LINE_W-1:0] data_q;
        logic [THR_W-1:0]  thr_q;

        assign clr      = (state_q == RESP) && (owner_q == 1'(gi));
        assign occ      = v_q && !clr;
        assign drop[gi] = req_v[gi] && occ;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                v_q    <= 1'b0;
                st_q   <= 1'b0;
                addr_q <= '0;
                data_q <= '0;
                thr_q  <= '0;
            end else begin
                if (clr) v_q <= 1'b0;
                if (req_v[gi] && !occ) begin
                    v_q    <= 1'b1;
                    st_q   <= req_st[gi];
                    addr_q <= req_addr[gi];
                    data_q <= req_data[gi];
                    thr_q  <= req_thr[gi];
                end
            end
        end

        assign slot_v[gi]    = v_q;
        assign slot_st[gi]   = st_q;
        assign slot_addr[gi] = addr_q;
        assign slot_data[gi] = data_q;
        assign slot_thr[gi]  = thr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rdata_q      <= '0;
            rerr_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            rerr_q       <= rerr_d;
            if (|drop) perr_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        rerr_d       = rerr_q;
        case (state_q)
            IDLE: begin
                if (|slot_v) begin
                    owner_d      = (&slot_v) ? ~last_grant_q : slot_v[1];
                    last_grant_d = owner_d;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real response wins over a timeout landing in the same cycle.
                if (mem_rsp_valid) begin
                    rdata_d = slot_st[owner_q] ? '0 : mem_rsp_data;
                    rerr_d  = mem_rsp_error;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid    = (state_q == ISSUE);
        mem_req_addr     = mem_req_valid ? slot_addr[owner_q] : '0;
        mem_req_is_store = mem_req_valid && slot_st[owner_q];
        mem_req_data     = mem_req_valid ? slot_data[owner_q] : '0;
        ic_rsp_valid     = (state_q == RESP) && !owner_q;
        dc_rsp_valid     = (state_q == RESP) && owner_q;
        ic_rsp_data      = ic_rsp_valid ? rdata_q : '0;
        ic_rsp_error     = ic_rsp_valid && rerr_q;
        ic_rsp_thread    = ic_rsp_valid ? slot_thr[0] : '0;
        dc_rsp_data      = dc_rsp_valid ? rdata_q : '0;
        dc_rsp_error     = dc_rsp_valid && rerr_q;
        dc_rsp_thread    = dc_rsp_valid ? slot_thr[1] : '0;
        protocol_err     = perr_q;
    end
endmodule

// File: doc/miss_mem_arbiter.md
# miss_mem_arbiter

Arbitrates line-fill and write-back traffic from the instruction-cache and data-cache miss ports onto a single main-memory port. It sits directly downstream of the cache top's miss interface (`req_valid_miss`/`req_info_miss`/`req_thread_id_miss`) and returns `rsp_valid_miss`/`rsp_data_miss`/`rsp_bus_error`/`rsp_thread_id` to the requester. One memory transaction is in flight at a time. The block applies round-robin fairness and enforces a response timeout that converts a hung memory access into a bus error.

## Interface
- `LINE_W`, 128: cache line width, in bits.
- `ADDR_W`, 20: physical address width.
- `THR_W`, 2: thread-id width.
- `TIMEOUT`, 64: maximum number of WAIT cycles before a bus error is returned (≥2).
- `clock`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low.
- `ic_req_valid` / `dc_req_valid`  in  1: single-cycle miss request pulse from each source.
- `ic_req_addr` / `dc_req_addr`  in  ADDR_W: line-aligned physical address.
- `ic_req_is_store` / `dc_req_is_store`  in  1: 1 = write-back, 0 = fill. The I$ always drives 0.
- `ic_req_data` / `dc_req_data`  in  LINE_W: write-back data.
- `ic_req_thread` / `dc_req_thread`  in  THR_W: requesting thread.
- `ic_rsp_valid` / `dc_rsp_valid`  out  1: one-cycle response pulse.
- `ic_rsp_data` / `dc_rsp_data`  out  LINE_W: fill data.
- `ic_rsp_error` / `dc_rsp_error`  out  1: bus error qualifier.
- `ic_rsp_thread` / `dc_rsp_thread`  out  THR_W: echoed thread id.
- `mem_req_valid`  out  1: request to memory; held until accepted.
- `mem_req_ready`  in  1: memory accepts the request when `mem_req_valid` & `mem_req_ready`.
- `mem_req_addr`, `mem_req_is_store`, `mem_req_data`  out: the granted request's fields.
- `mem_rsp_valid`  in  1: memory completion pulse.
- `mem_rsp_data`  in  LINE_W: memory completion data.
- `mem_rsp_error`  in  1: memory completion error.
- `protocol_err`  out  1: sticky; set when a source issues a request while its own request is still pending.

## Operation
- Each source has a one-deep pending slot (valid, addr, is_store, data, thread). A slot is captured on `*_req_valid`.
  - If the slot is already valid, the new request is dropped, `protocol_err` is set, and the slot contents are kept.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any slot is valid, grant one source, latch the owner, and go to ISSUE.
  - If both slots are valid, grant the source that is not `last_grant`; `last_grant` then updates.
  - After reset, `last_grant` = D$, so the I$ wins the first tie.
- ISSUE:
  - `mem_req_valid`=1, driving the owner slot's fields.
  - On ready, go to WAIT and clear the timeout counter.
  - `mem_rsp_valid` is ignored in ISSUE.
- WAIT:
  - The counter increments each cycle.
  - On `mem_rsp_valid`, capture data and error, then go to RESP.
  - When the counter reaches TIMEOUT-1 with no response, capture data=0 and error=1, then go to RESP.
  - If `mem_rsp_valid` arrives in the same cycle as the timeout, the memory response wins.
- RESP:
  - Pulse the owner's `*_rsp_valid` with the captured data, error, and slot thread.
  - Clear the owner's slot and return to IDLE.
  - For stores, rsp data is forced to 0; the pulse acts as the write-back ack.
- A `mem_rsp_valid` seen in IDLE, ISSUE or RESP is discarded; this covers late responses after a timeout.
- A new request to the owner's slot in the same cycle as its RESP clear is captured: the clear applies first, then the capture.
- The non-owner slot may capture at any time.
- Counter width is $clog2(TIMEOUT); it never wraps, because the FSM leaves WAIT first.

## Timing
- Reset (asynchronous assert, synchronous deassert use):
  - State = IDLE, slots invalid, counter 0, `last_grant`=D$, `protocol_err`=0.
  - All `*_rsp_valid`, `mem_req_valid`, data, error and thread outputs are 0.
- Reset asserted mid-transaction aborts it; no response is ever issued for that transaction.
- Request pulse at cycle N → slot valid at N+1 → ISSUE (`mem_req_valid`=1) at N+2.
- With ready=1, WAIT at N+3. A `mem_rsp_valid` at N+3 gives `*_rsp_valid` at N+4. Minimum latency is 4 cycles.
- All outputs are registered or decoded from state and registers only; there is no combinational path from the memory response to the cache response.
- Back-to-back transactions: IDLE costs one cycle between RESP and the next ISSUE.

## Test plan
- Single D$ fill, addr 0x00140, thread 2; memory ready immediately and responds 3 cycles after acceptance with data 0xA5…A5 → `dc_rsp_valid` for exactly 1 cycle with that data, error=0, thread=2, 6 cycles after the request.
- I$ and D$ request in the same cycle, then both repeat after their responses → grant order I$, D$, I$, D$ (alternating).
- Memory never responds, TIMEOUT=64 → `dc_rsp_valid` with error=1 and data=0, 64 WAIT cycles after acceptance. A later `mem_rsp_valid` produces no response pulse.
- D$ store of 0xFFFF…0 with `mem_req_ready` held low for 5 cycles → `mem_req_valid` and all fields stable for those 5 cycles; ack with data=0 after the response.
- Second `ic_req_valid` while the first is pending → `protocol_err`=1 (sticky); the original request completes with its original addr.
- Reset asserted while in WAIT → all outputs are 0 immediately. After release, a new I$ request completes normally with the minimum 4-cycle latency.
